// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: per-source request FIFOs for the instruction and data caches feeding one
// registered valid/ready command/address channel to L2, with round-robin or data-priority
// arbitration and saturating per-source grant counters.
module l2_request_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic        i_req_valid,
    input  logic [1:0]  i_req_cmd,
    input  logic [25:0] i_req_addr,
    output logic        i_req_ready,
    input  logic        d_req_valid,
    input  logic [1:0]  d_req_cmd,
    input  logic [25:0] d_req_addr,
    output logic        d_req_ready,
    output logic        l2_valid,
    output logic [1:0]  l2_cmd,
    output logic [25:0] l2_addr,
    output logic        l2_src,
    input  logic        l2_ready,
    output logic [31:0] i_grants,
    output logic [31:0] d_grants
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef logic [27:0] msg_t;

    msg_t          r_i_mem [DEPTH];
    msg_t          r_d_mem [DEPTH];
    logic [PW-1:0] r_i_wp, r_i_rp, r_d_wp, r_d_rp;
    logic [CW-1:0] r_i_cnt, r_d_cnt;

    logic          r_valid;
    logic [1:0]    r_cmd;
    logic [25:0]   r_addr;
    logic          r_src;
    logic          r_last_d;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_i_grants, r_d_grants;

    logic w_i_full, w_d_full, w_i_push, w_d_push;
    logic w_i_ne, w_d_ne, w_load, w_grant_i, w_pop_i, w_pop_d;

    // Ready looks only at the stored count, so a same-cycle pop never frees a slot early.
    assign w_i_full    = (r_i_cnt == CW'(DEPTH));
    assign w_d_full    = (r_d_cnt == CW'(DEPTH));
    assign i_req_ready = !w_i_full;
    assign d_req_ready = !w_d_full;
    assign w_i_push    = i_req_valid && !w_i_full;
    assign w_d_push    = d_req_valid && !w_d_full;
    assign w_i_ne      = (r_i_cnt != '0);
    assign w_d_ne      = (r_d_cnt != '0);
    assign w_load      = !r_valid || l2_ready;
    assign w_pop_i     = w_load && w_i_ne && w_grant_i;
    assign w_pop_d     = w_load && w_d_ne && !w_grant_i;

    // Arbitration: the non-empty FIFO wins; on a tie use RR pointer or priority/starvation guard.
    always_comb begin
        w_grant_i = w_i_ne;
        if (w_i_ne && w_d_ne) begin
            if (ARB_MODE == 0) begin
                w_grant_i = r_last_d;
            end else begin
                w_grant_i = (r_starve >= SW'(STARVE_LIMIT));
            end
        end
    end

    // Instruction FIFO storage and pointers.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_i_wp  <= '0;
            r_i_rp  <= '0;
            r_i_cnt <= '0;
        end else begin
            if (w_i_push) begin
                r_i_mem[r_i_wp] <= {i_req_cmd, i_req_addr};
                r_i_wp          <= r_i_wp + 1'b1;
            end
            if (w_pop_i) begin
                r_i_rp <= r_i_rp + 1'b1;
            end
            r_i_cnt <= r_i_cnt + CW'(w_i_push) - CW'(w_pop_i);
        end
    end

    // Data FIFO storage and pointers.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_d_wp  <= '0;
            r_d_rp  <= '0;
            r_d_cnt <= '0;
        end else begin
            if (w_d_push) begin
                r_d_mem[r_d_wp] <= {d_req_cmd, d_req_addr};
                r_d_wp          <= r_d_wp + 1'b1;
            end
            if (w_pop_d) begin
                r_d_rp <= r_d_rp + 1'b1;
            end
            r_d_cnt <= r_d_cnt + CW'(w_d_push) - CW'(w_pop_d);
        end
    end

    // Output register, arbitration history and grant counters; loads only on an open slot.
    always_ff @(posedge Clock) begin
        if (clear) begin
            r_valid    <= 1'b0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_src      <= 1'b0;
            r_last_d   <= 1'b1;
            r_starve   <= '0;
            r_i_grants <= '0;
            r_d_grants <= '0;
        end else if (w_load) begin
            r_valid <= w_i_ne || w_d_ne;
            if (w_pop_i) begin
                {r_cmd, r_addr} <= r_i_mem[r_i_rp];
                r_src           <= 1'b0;
                r_last_d        <= 1'b0;
                r_starve        <= '0;
                if (r_i_grants != 32'hFFFF_FFFF) begin
                    r_i_grants <= r_i_grants + 32'd1;
                end
            end else if (w_pop_d) begin
                {r_cmd, r_addr} <= r_d_mem[r_d_rp];
                r_src           <= 1'b1;
                r_last_d        <= 1'b1;
                if (!w_i_ne) begin
                    r_starve <= '0;
                end else if (r_starve != SW'(STARVE_LIMIT)) begin
                    r_starve <= r_starve + 1'b1;
                end
                if (r_d_grants != 32'hFFFF_FFFF) begin
                    r_d_grants <= r_d_grants + 32'd1;
                end
            end else begin
                r_starve <= '0;
            end
        end
    end

    assign l2_valid = r_valid;
    assign l2_cmd   = r_cmd;
    assign l2_addr  = r_addr;
    assign l2_src   = r_src;
    assign i_grants = r_i_grants;
    assign d_grants = r_d_grants;
endmodule

// File: tb/tb_l2_request_arbiter.sv
// Bench for l2_request_arbiter: a round-robin and a data-priority instance share one stimulus
// stream; each is compared every cycle against a queue-based reference model.
module tb_l2_request_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 3;

    typedef logic [27:0] msg_t;
    typedef msg_t msg_q_t[$];
    typedef int int_q_t[$];
    typedef struct packed {
        logic        ov;
        logic [1:0]  cmd;
        logic [25:0] addr;
        logic        src;
        logic        last_d;
        int unsigned starve;
        logic [31:0] ig;
        logic [31:0] dg;
    } mst_t;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic        i_req_valid = 1'b0, d_req_valid = 1'b0, l2_ready = 1'b0;
    logic [1:0]  i_req_cmd = '0, d_req_cmd = '0;
    logic [25:0] i_req_addr = '0, d_req_addr = '0;

    logic        o_i_ready [2];
    logic        o_d_ready [2];
    logic        o_valid   [2];
    logic [1:0]  o_cmd     [2];
    logic [25:0] o_addr    [2];
    logic        o_src     [2];
    logic [31:0] o_ig      [2];
    logic [31:0] o_dg      [2];

    int     checks = 0;
    int     errors = 0;
    mst_t   ms [2];
    msg_q_t qi0, qd0, qi1, qd1;
    int_q_t log0, log1;

    always #5 Clock = ~Clock;

    l2_request_arbiter #(.DEPTH(DEPTH), .ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_rr (
        .Clock(Clock), .clear(clear),
        .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr),
        .i_req_ready(o_i_ready[0]),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd), .d_req_addr(d_req_addr),
        .d_req_ready(o_d_ready[0]),
        .l2_valid(o_valid[0]), .l2_cmd(o_cmd[0]), .l2_addr(o_addr[0]), .l2_src(o_src[0]),
        .l2_ready(l2_ready), .i_grants(o_ig[0]), .d_grants(o_dg[0])
    );

    l2_request_arbiter #(.DEPTH(DEPTH), .ARB_MODE(1), .STARVE_LIMIT(LIMIT)) u_pr (
        .Clock(Clock), .clear(clear),
        .i_req_valid(i_req_valid), .i_req_cmd(i_req_cmd), .i_req_addr(i_req_addr),
        .i_req_ready(o_i_ready[1]),
        .d_req_valid(d_req_valid), .d_req_cmd(d_req_cmd), .d_req_addr(d_req_addr),
        .d_req_ready(o_d_ready[1]),
        .l2_valid(o_valid[1]), .l2_cmd(o_cmd[1]), .l2_addr(o_addr[1]), .l2_src(o_src[1]),
        .l2_ready(l2_ready), .i_grants(o_ig[1]), .d_grants(o_dg[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mst_t reset_state();
        mst_t s;
        s = '0;
        s.last_d = 1'b1;
        return s;
    endfunction

    // One clock edge of the reference behaviour, using pre-edge queue contents.
    task automatic model_step(input int mode, inout mst_t s, inout msg_q_t qi, inout msg_q_t qd);
        bit   push_i, push_d, ine, dne, gi;
        msg_t m;
        if (clear) begin
            s = reset_state();
            qi.delete();
            qd.delete();
            return;
        end
        push_i = i_req_valid && (qi.size() < DEPTH);
        push_d = d_req_valid && (qd.size() < DEPTH);
        if (!s.ov || l2_ready) begin
            ine = qi.size() > 0;
            dne = qd.size() > 0;
            if (ine && dne) gi = (mode == 0) ? s.last_d : (s.starve >= LIMIT);
            else gi = ine;
            s.ov = ine || dne;
            if (ine && gi) begin
                m = qi.pop_front();
                {s.cmd, s.addr} = m;
                s.src = 1'b0;
                s.last_d = 1'b0;
                s.starve = 0;
                if (s.ig != 32'hFFFF_FFFF) s.ig++;
            end else if (dne) begin
                m = qd.pop_front();
                {s.cmd, s.addr} = m;
                s.src = 1'b1;
                s.last_d = 1'b1;
                s.starve = ine ? s.starve + 1 : 0;
                if (s.dg != 32'hFFFF_FFFF) s.dg++;
            end else begin
                s.starve = 0;
            end
        end
        if (push_i) qi.push_back({i_req_cmd, i_req_addr});
        if (push_d) qd.push_back({d_req_cmd, d_req_addr});
    endtask

    task automatic check_inst(input int k, input mst_t s, input int ni, input int nd);
        chk($sformatf("u%0d l2_valid", k), o_valid[k], s.ov);
        chk($sformatf("u%0d l2_cmd", k), o_cmd[k], s.cmd);
        chk($sformatf("u%0d l2_addr", k), o_addr[k], s.addr);
        chk($sformatf("u%0d l2_src", k), o_src[k], s.src);
        chk($sformatf("u%0d i_req_ready", k), o_i_ready[k], ni < DEPTH);
        chk($sformatf("u%0d d_req_ready", k), o_d_ready[k], nd < DEPTH);
        chk($sformatf("u%0d i_grants", k), o_ig[k], s.ig);
        chk($sformatf("u%0d d_grants", k), o_dg[k], s.dg);
    endtask

    // Log delivered sources, advance one edge, update the models, then compare.
    task automatic step();
        if (!clear && l2_ready) begin
            if (o_valid[0]) log0.push_back(int'(o_src[0]));
            if (o_valid[1]) log1.push_back(int'(o_src[1]));
        end
        @(posedge Clock);
        model_step(0, ms[0], qi0, qd0);
        model_step(1, ms[1], qi1, qd1);
        #1;
        check_inst(0, ms[0], qi0.size(), qd0.size());
        check_inst(1, ms[1], qi1.size(), qd1.size());
    endtask

    task automatic check_log(input string tag, input int_q_t lg, input int_q_t ex);
        chk({tag, " count"}, lg.size(), ex.size());
        for (int i = 0; i < ex.size() && i < lg.size(); i++) begin
            chk($sformatf("%s order[%0d]", tag, i), lg[i], ex[i]);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        step();
        clear = 1'b0;
        log0.delete();
        log1.delete();
    endtask

    initial begin
        int_q_t ex;
        ms[0] = reset_state();
        ms[1] = reset_state();

        // Reset state.
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            chk("reset l2_valid", o_valid[k], 1'b0);
            chk("reset l2_addr", o_addr[k], 26'h0);
            chk("reset i_ready", o_i_ready[k], 1'b1);
            chk("reset d_grants", o_dg[k], 32'd0);
        end
        clear = 1'b0;

        // Single I message: presented two edges after its push.
        l2_ready = 1'b1;
        i_req_valid = 1'b1;
        i_req_cmd = 2'd2;
        i_req_addr = 26'h0AB;
        step();
        idle_inputs();
        chk("t1 not yet valid", o_valid[0], 1'b0);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1 valid", o_valid[k], 1'b1);
            chk("t1 src", o_src[k], 1'b0);
            chk("t1 cmd", o_cmd[k], 2'd2);
            chk("t1 addr", o_addr[k], 26'h0AB);
            chk("t1 i_grants", o_ig[k], 32'd1);
        end
        step();

        // Three simultaneous pushes per source, L2 always ready.
        do_clear();
        l2_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            i_req_valid = 1'b1;
            d_req_valid = 1'b1;
            i_req_cmd = 2'($urandom);
            d_req_cmd = 2'($urandom);
            i_req_addr = 26'($urandom);
            d_req_addr = 26'($urandom);
            step();
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) step();
        ex = '{0, 1, 0, 1, 0, 1};
        check_log("t2 rr", log0, ex);
        ex = '{1, 1, 1, 0, 0, 0};
        check_log("t2 pr", log1, ex);
        for (int k = 0; k < 2; k++) begin
            chk("t2 i_grants", o_ig[k], 32'd3);
            chk("t2 d_grants", o_dg[k], 32'd3);
        end

        // Five D and two I messages: starvation guard forces I in after three D grants.
        do_clear();
        l2_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            d_req_valid = 1'b1;
            d_req_addr = 26'($urandom);
            i_req_valid = (c < 2);
            i_req_addr = 26'($urandom);
            step();
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) step();
        ex = '{1, 1, 1, 0, 1, 1, 0};
        check_log("t3 pr", log1, ex);
        ex = '{0, 1, 0, 1, 1, 1, 1};
        check_log("t3 rr", log0, ex);

        // L2 stalled for ten cycles while both sources keep pushing.
        do_clear();
        l2_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            i_req_valid = (c < 2 * DEPTH);
            d_req_valid = (c < 2 * DEPTH);
            i_req_cmd = 2'($urandom);
            d_req_cmd = 2'($urandom);
            i_req_addr = 26'($urandom);
            d_req_addr = 26'($urandom);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            chk("t4 i full", o_i_ready[k], 1'b0);
            chk("t4 d full", o_d_ready[k], 1'b0);
        end

        // Full D FIFO popped in the same cycle as a push attempt: push refused.
        i_req_valid = 1'b0;
        d_req_valid = 1'b1;
        d_req_addr = 26'h3FF_FFFF;
        l2_ready = 1'b1;
        chk("t5 pre ready", o_d_ready[0], 1'b0);
        step();
        d_req_valid = 1'b0;
        for (int k = 0; k < 2; k++) chk("t5 ready after pop", o_d_ready[k], 1'b1);
        for (int c = 0; c < 12; c++) step();

        // Clear while a message is stalled on the output and both FIFOs hold data.
        do_clear();
        l2_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i_req_valid = 1'b1;
            d_req_valid = (c < 2);
            i_req_addr = 26'($urandom);
            d_req_addr = 26'($urandom);
            step();
        end
        idle_inputs();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        l2_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("t6 valid", o_valid[k], 1'b0);
            chk("t6 i_ready", o_i_ready[k], 1'b1);
            chk("t6 i_grants", o_ig[k], 32'd0);
            chk("t6 d_grants", o_dg[k], 32'd0);
        end
        for (int c = 0; c < 3; c++) step();
        for (int k = 0; k < 2; k++) chk("t6 no stale", o_valid[k], 1'b0);

        // Randomized traffic with occasional clears.
        for (int c = 0; c < 800; c++) begin
            clear = ($urandom_range(0, 99) == 0);
            i_req_valid = 1'($urandom_range(0, 1));
            d_req_valid = ($urandom_range(0, 3) != 0);
            l2_ready = ($urandom_range(0, 3) != 0);
            i_req_cmd = 2'($urandom);
            d_req_cmd = 2'($urandom);
            i_req_addr = 26'($urandom);
            d_req_addr = 26'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
